// File: rtl/lsu_pkg.sv
// Shared types and helpers for the cache load/store adapter.
//   size_e     : access size encoding (1/2/4/8 bytes)
//   state_e    : adapter FSM states
//   size_bytes : access size in bytes
//   low_mask   : address bits that must be zero for an aligned access
//   le_pack    : lay a right-justified value out as ascending-address bytes
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_STORE,
    ST_GAP,
    ST_RESP
  } state_e;

  localparam int unsigned BLOCK_BITS = 512;
  localparam int unsigned WORD_BITS  = 64;

  function automatic logic [3:0] size_bytes(input size_e size);
    return 4'd1 << size;
  endfunction

  function automatic logic [2:0] low_mask(input size_e size);
    return 3'(size_bytes(size) - 4'd1);
  endfunction

  // Byte k of the result (ascending slice) is value bits [k*8+7:k*8].
  function automatic logic [0:WORD_BITS-1] le_pack(input logic [WORD_BITS-1:0] v);
    logic [0:WORD_BITS-1] r;
    r = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      r[k*8 +: 8] = v[k*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte lane shared by the load and read-modify-write paths.
//   block     in  cache block, byte A at block[A*8 +: 8]
//   offset    in  effective (aligned) byte offset within the block
//   size      in  access size
//   sign_ext  in  sign-extend load data when 1
//   wdata     in  right-justified store data
//   load_data out extracted, extended load value
//   merged    out doubleword at offset with the store bytes merged in
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [0:BLOCK_BITS-1] block,
  input  logic [5:0]            offset,
  input  size_e                 size,
  input  logic                  sign_ext,
  input  logic [WORD_BITS-1:0]  wdata,
  output logic [WORD_BITS-1:0]  load_data,
  output logic [0:WORD_BITS-1]  merged
);

  logic [WORD_BITS-1:0] dword;
  logic [WORD_BITS-1:0] shifted;

  // Little-endian view of the addressed doubleword.
  always_comb begin
    dword = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      dword[k*8 +: 8] = block[32'(offset[5:3])*64 + k*8 +: 8];
    end
  end

  assign shifted = dword >> {offset[2:0], 3'b000};

  always_comb begin
    load_data = '0;
    unique case (size)
      SZ_B: load_data = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
      SZ_H: load_data = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
      SZ_W: load_data = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
      SZ_D: load_data = shifted;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    int unsigned lo;
    int unsigned hi;
    lo     = 32'(offset[2:0]);
    hi     = lo + 32'(size_bytes(size));
    merged = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (k >= lo && k < hi) begin
        merged[k*8 +: 8] = wdata[(k - lo)*8 +: 8];
      end else begin
        merged[k*8 +: 8] = dword[k*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/cache_lsu_adapter.sv
// Load/store front end for the set-associative read/write cache.
// Accepts core loads/stores on a valid/ready channel, drives the cache
// reqcyc/addr/writeEnable/write_data handshake, returns extended load data,
// and performs sub-doubleword stores as read-modify-write.
// Optional build macro: ALIGN_CHECK_EN (misaligned requests fault without a
// cache access; otherwise low address bits are silently cleared).
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready/req_addr/req_store/req_size/req_signed/req_wdata : core request
//   resp_valid/resp_rdata/resp_fault                                     : core response
//   cache_reqcyc/cache_addr/cache_writeEnable/cache_write_data           : cache request
//   cache_respcyc/cache_read_data                                        : cache response
module cache_lsu_adapter
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 64,
  parameter int unsigned BLOCK_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [WORD_BITS-1:0]  req_wdata,
  output logic                  resp_valid,
  output logic [WORD_BITS-1:0]  resp_rdata,
  output logic                  resp_fault,
  output logic                  cache_reqcyc,
  output logic [ADDR_BITS-1:0]  cache_addr,
  output logic                  cache_writeEnable,
  output logic [0:WORD_BITS-1]  cache_write_data,
  input  logic                  cache_respcyc,
  input  logic [0:BLOCK_BITS-1] cache_read_data
);

  localparam int unsigned OFF_BITS = $clog2(BLOCK_BYTES);

  state_e                 state, next_state;
  logic                   active;
  logic [ADDR_BITS-1:0]   addr_q;
  size_e                  size_q;
  logic                   signed_q;
  logic                   store_q;
  logic                   rmw_q;
  logic [WORD_BITS-1:0]   wdata_q;
  logic [WORD_BITS-1:0]   rdata_q;
  logic [0:WORD_BITS-1]   wr_q;
  logic [ADDR_BITS-1:0]   eff_addr;
  logic                   accept;
  logic                   fault_now;
  logic [WORD_BITS-1:0]   lane_load;
  logic [0:WORD_BITS-1]   lane_merged;

  assign eff_addr = {req_addr[ADDR_BITS-1:3], req_addr[2:0] & ~low_mask(size_e'(req_size))};
  assign accept   = (state == ST_IDLE) && active && req_valid;

`ifdef ALIGN_CHECK_EN
  logic fault_q;

  assign fault_now  = |(req_addr[2:0] & low_mask(size_e'(req_size)));
  assign resp_fault = fault_q && (state == ST_RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= fault_now;
    end
  end
`else
  assign fault_now  = 1'b0;
  assign resp_fault = 1'b0;
`endif

  lsu_byte_lane u_lane (
    .block     (cache_read_data),
    .offset    (addr_q[OFF_BITS-1:0]),
    .size      (size_q),
    .sign_ext  (signed_q),
    .wdata     (wdata_q),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state        = state;
    req_ready         = 1'b0;
    cache_reqcyc      = 1'b0;
    cache_writeEnable = 1'b0;
    resp_valid        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = active;
        if (accept) begin
          if (fault_now)                         next_state = ST_RESP;
          else if (!req_store)                   next_state = ST_LOAD;
          else if (size_e'(req_size) == SZ_D)    next_state = ST_STORE;
          else                                   next_state = ST_RMW_RD;
        end
      end
      ST_LOAD, ST_RMW_RD: begin
        cache_reqcyc = 1'b1;
        if (cache_respcyc) next_state = ST_GAP;
      end
      ST_RMW_WR, ST_STORE: begin
        cache_reqcyc      = 1'b1;
        cache_writeEnable = 1'b1;
        if (cache_respcyc) next_state = ST_GAP;
      end
      ST_GAP: begin
        next_state = rmw_q ? ST_RMW_WR : ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // active keeps req_ready low while reset is held and for no longer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      addr_q   <= '0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      store_q  <= 1'b0;
      rmw_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_q     <= '0;
    end else begin
      active <= 1'b1;
      if (accept) begin
        addr_q   <= eff_addr;
        size_q   <= size_e'(req_size);
        signed_q <= req_signed;
        store_q  <= req_store;
        wdata_q  <= req_wdata;
        wr_q     <= le_pack(req_wdata);
        if (fault_now) rdata_q <= '0;
      end
      if (state == ST_LOAD && cache_respcyc) begin
        rdata_q <= lane_load;
      end
      // rmw_q steers the first GAP to RMW_WR and is consumed there.
      if (state == ST_RMW_RD && cache_respcyc) begin
        wr_q  <= lane_merged;
        rmw_q <= 1'b1;
      end
      if (state == ST_GAP) begin
        rmw_q <= 1'b0;
      end
    end
  end

  assign cache_addr       = {addr_q[ADDR_BITS-1:3], 3'b000};
  assign cache_write_data = wr_q;
  assign resp_rdata       = (state == ST_RESP && store_q) ? '0 : rdata_q;

endmodule

// File: tb/tb_cache_lsu_adapter.sv
// Directed self-checking bench for cache_lsu_adapter with a simple cache
// responder (programmable respcyc latency, single shared block).
module tb_cache_lsu_adapter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [63:0]  req_addr = '0;
  logic         req_store = 1'b0;
  logic [1:0]   req_size = '0;
  logic         req_signed = 1'b0;
  logic [63:0]  req_wdata = '0;
  logic         resp_valid;
  logic [63:0]  resp_rdata;
  logic         resp_fault;
  logic         cache_reqcyc;
  logic [63:0]  cache_addr;
  logic         cache_writeEnable;
  logic [0:63]  cache_write_data;
  logic         cache_respcyc;
  logic [0:511] blk = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_lsu_adapter #(.ADDR_BITS(64), .BLOCK_BYTES(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_store         (req_store),
    .req_size          (req_size),
    .req_signed        (req_signed),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_fault        (resp_fault),
    .cache_reqcyc      (cache_reqcyc),
    .cache_addr        (cache_addr),
    .cache_writeEnable (cache_writeEnable),
    .cache_write_data  (cache_write_data),
    .cache_respcyc     (cache_respcyc),
    .cache_read_data   (blk)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cache responder: respcyc after lat extra cycles of reqcyc.
  int          lat = 0;
  int          cnt;
  int          wr_count = 0;
  logic [63:0] wr_addr = '0;
  logic [0:63] wr_data = '0;
  logic [63:0] rd_addr = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= 0;
      cache_respcyc <= 1'b0;
    end else begin
      cache_respcyc <= 1'b0;
      if (cache_reqcyc && !cache_respcyc) begin
        if (!cache_writeEnable) rd_addr <= cache_addr;
        if (cnt >= lat) begin
          cache_respcyc <= 1'b1;
          cnt           <= 0;
          if (cache_writeEnable) begin
            wr_count <= wr_count + 1;
            wr_addr  <= cache_addr;
            wr_data  <= cache_write_data;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  // Cumulative activity counters, sampled mid-cycle.
  int   rq_cyc = 0;
  int   we_cyc = 0;
  int   after_resp = 0;
  int   resp_seen = 0;
  logic prev_resp = 1'b0;

  always @(negedge clk) begin
    if (cache_reqcyc) rq_cyc++;
    if (cache_reqcyc && cache_writeEnable) we_cyc++;
    if (prev_resp && cache_reqcyc) after_resp++;
    prev_resp = cache_respcyc;
    if (resp_valid) resp_seen++;
  end

  int          last_lat;
  int          last_busy;
  logic [63:0] last_rdata;
  logic        last_fault;

  // Issue one request; cycle count runs from the accepting edge to resp_valid.
  task automatic do_req(input logic [63:0] a, input logic st, input logic [1:0] sz,
                        input logic sg, input logic [63:0] wd, input bit hold);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    n = 0;
    last_busy = 0;
    last_lat  = -1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (req_ready) last_busy++;
      if (resp_valid) begin
        last_lat   = n;
        last_rdata = resp_rdata;
        last_fault = resp_fault;
        break;
      end
    end
    if (last_lat < 0) check("resp_timeout", 64'(n), 64'd0);
  endtask

  task automatic fill_ramp();
    for (int unsigned i = 0; i < 64; i++) blk[i*8 +: 8] = 8'(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int s_rq, s_we, s_wr, s_resp, s_after;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_ctl", {60'd0, resp_valid, resp_fault, cache_reqcyc, cache_writeEnable}, 64'd0);
    check("rst_cache_addr", cache_addr, 64'd0);
    check("rst_write_data", cache_write_data, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Reset in the middle of RMW_RD
    lat = 10;
    req_valid = 1'b1; req_addr = 64'h2012; req_store = 1'b1; req_size = 2'd1; req_wdata = 64'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rmw_rd_active", {62'd0, cache_reqcyc, cache_writeEnable}, 64'd2);
    s_resp = resp_seen;
    reset = 1'b0;
    #1;
    check("rst_mid_reqcyc", 64'(cache_reqcyc), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ready_after", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("rst_mid_no_reqcyc", 64'(cache_reqcyc), 64'd0);
    check("rst_mid_no_resp", 64'(resp_seen - s_resp), 64'd0);

    // Signed byte loads
    lat = 0;
    fill_ramp();
    do_req(64'h1007, 1'b0, 2'd0, 1'b1, 64'd0, 1'b0);
    check("lb_lat", 64'(last_lat), 64'd4);
    check("lb_addr", rd_addr, 64'h1000);
    check("lb_data", last_rdata, 64'h0000000000000007);
    blk[7*8 +: 8] = 8'h80;
    do_req(64'h1007, 1'b0, 2'd0, 1'b1, 64'd0, 1'b0);
    check("lb_neg_data", last_rdata, 64'hFFFFFFFFFFFFFF80);

    // 2-byte RMW store
    for (int unsigned i = 0; i < 64; i++) blk[i*8 +: 8] = 8'h11;
    s_rq = rq_cyc; s_we = we_cyc; s_wr = wr_count;
    do_req(64'h2012, 1'b1, 2'd1, 1'b0, 64'h000000000000BEEF, 1'b0);
    check("sh_lat", 64'(last_lat), 64'd7);
    check("sh_rd_addr", rd_addr, 64'h2010);
    check("sh_wr_count", 64'(wr_count - s_wr), 64'd1);
    check("sh_wr_addr", wr_addr, 64'h2010);
    check("sh_wr_data", wr_data, 64'h1111EFBE11111111);
    check("sh_reqcyc_cycles", 64'(rq_cyc - s_rq), 64'd4);
    check("sh_we_cycles", 64'(we_cyc - s_we), 64'd2);
    check("sh_resp_rdata", last_rdata, 64'd0);
    @(negedge clk);
    check("rdata_hold", resp_rdata, 64'hFFFFFFFFFFFFFF80);

    // 8-byte store with a long cache stall
    lat = 20;
    s_rq = rq_cyc; s_we = we_cyc; s_wr = wr_count;
    do_req(64'h3008, 1'b1, 2'd3, 1'b0, 64'h0123456789ABCDEF, 1'b0);
    check("sd_lat", 64'(last_lat), 64'd24);
    check("sd_reqcyc_cycles", 64'(rq_cyc - s_rq), 64'd22);
    check("sd_we_cycles", 64'(we_cyc - s_we), 64'd22);
    check("sd_wr_count", 64'(wr_count - s_wr), 64'd1);
    check("sd_wr_addr", wr_addr, 64'h3008);
    check("sd_wr_data", wr_data, 64'hEFCDAB8967452301);

    // Misaligned 4-byte load
    lat = 0;
    fill_ramp();
    s_rq = rq_cyc;
    do_req(64'h4002, 1'b0, 2'd2, 1'b0, 64'd0, 1'b0);
`ifdef ALIGN_CHECK_EN
    check("lw_mis_lat", 64'(last_lat), 64'd1);
    check("lw_mis_fault", 64'(last_fault), 64'd1);
    check("lw_mis_rdata", last_rdata, 64'd0);
    check("lw_mis_no_reqcyc", 64'(rq_cyc - s_rq), 64'd0);
`else
    check("lw_mis_lat", 64'(last_lat), 64'd4);
    check("lw_mis_fault", 64'(last_fault), 64'd0);
    check("lw_mis_addr", rd_addr, 64'h4000);
    check("lw_mis_rdata", last_rdata, 64'h0000000003020100);
`endif

    // Back-to-back loads with req_valid held
    blk[8'h3F*8 +: 8] = 8'hF0;
    s_after = after_resp;
    do_req(64'h5009, 1'b0, 2'd0, 1'b0, 64'd0, 1'b1);
    check("b2b0_lat", 64'(last_lat), 64'd4);
    check("b2b0_busy_ready", 64'(last_busy), 64'd0);
    check("b2b0_data", last_rdata, 64'h0000000000000009);
    do_req(64'h5010, 1'b0, 2'd3, 1'b0, 64'd0, 1'b1);
    check("b2b1_busy_ready", 64'(last_busy), 64'd0);
    check("b2b1_data", last_rdata, 64'h1716151413121110);
    do_req(64'h503E, 1'b0, 2'd1, 1'b1, 64'd0, 1'b0);
    check("b2b2_busy_ready", 64'(last_busy), 64'd0);
    check("b2b2_addr", rd_addr, 64'h5038);
    check("b2b2_data", last_rdata, 64'hFFFFFFFFFFFFF03E);
    check("b2b_gap_after_resp", 64'(after_resp - s_after), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
